pc_redirect_unit: RTL and testbench
===================================

Name: pc_redirect_unit

Overview:
- Program-counter sequencer for the IF stage.
- Consumes redirect requests from downstream and produces the fetch PC each cycle:
  - branch target resolved in EX;
  - pseudo-direct jump target formed in ID as {pc[31:28], instr[25:0], 2'b00};
  - register jump target (jr) from ID.
- Arbitrates simultaneous redirects, applies stalls, and emits a one-cycle flush pulse to squash IF/ID wrong-path instructions.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- PC_INC, 4, sequential increment in bytes.
- CNT_W, 16, width of redirect counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- stall  in  1  hazard stall; holds PC when no redirect
- br_valid  in  1  taken branch from EX
- br_target  in  32  branch target
- j_valid  in  1  j/jal from ID
- j_target  in  32  pseudo-direct jump target
- jr_valid  in  1  jr/jalr from ID
- jr_target  in  32  register jump target
- pc  out  32  current fetch address
- pc_valid  out  1  pc is a real fetch
- flush  out  1  squash IF/ID, one-cycle pulse
- redirect_cnt  out  CNT_W  saturating count of accepted redirects

Behaviour:
- Reset: clk and rst only; reset is synchronous and active-high. While rst=1 at a clock edge:
  - pc=RESET_PC, pc_valid=0, flush=0, redirect_cnt=0, state=BOOT.
  - Reset asserted mid-operation overrides everything, including a pending redirect.
- All outputs are registered. A redirect accepted at edge N shows pc=target and flush=1 after edge N.
- State BOOT: one cycle.
  - All request inputs are ignored.
  - Next edge: state=RUN, pc_valid=1, pc stays RESET_PC.
- State RUN, evaluated in priority order:
  1. br_valid: pc<=br_target. br has highest priority because it is the older instruction.
  2. Else j_valid: pc<=j_target.
  3. Else jr_valid: pc<=jr_target.
  4. Any accepted redirect: flush<=1, redirect_cnt+=1, state<=SQUASH.
  5. No redirect and stall=1: pc held, flush<=0.
  6. No redirect and stall=0: pc<=pc+PC_INC, modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000).
- A redirect overrides stall.
- State SQUASH: one cycle; flush=1 during it.
  - j_valid and jr_valid are ignored; they come from the squashed wrong-path ID slot.
  - br_valid is honoured exactly as in RUN: a new redirect, flush stays 1 for another cycle, state stays SQUASH, counter increments.
  - Otherwise the stall/increment rules of RUN apply and state<=RUN with flush<=0.
- pc_valid is 1 in RUN and SQUASH, 0 only during reset and BOOT.
- redirect_cnt saturates at all-ones and does not wrap.
- Lower two target bits are taken as given unless the optional feature is compiled in.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - Adds output misalign (1 bit, reset 0, sticky until rst).
  - An accepted-priority redirect whose target[1:0]!=2'b00 is dropped: pc follows the no-redirect rules, no flush, counter unchanged, misalign<=1.
  - A dropped request does not let a lower-priority request win that cycle.
- Undefined: no misalign port; misaligned targets are loaded unmodified.

Test Plan:
- Reset, then release, stall=0, no requests -> one cycle pc=0 with pc_valid=0; then pc=0 with pc_valid=1, then 4, 8, 12; flush stays 0.
- At pc=0x100, assert j_valid, j_target=0x0040_0020 for one cycle -> next pc=0x0040_0020 with flush=1 for one cycle; following pc=0x0040_0024; redirect_cnt=1.
- Same cycle br_valid (0x2000) and j_valid (0x3000) -> pc=0x2000; one flush; cnt+1. Then during SQUASH assert jr_valid (0x4000) -> ignored, pc=0x2004. Repeat with br_valid (0x5000) in SQUASH -> pc=0x5000, flush held two cycles.
- stall=1 for 3 cycles at pc=0x40 -> pc held at 0x40. Assert jr_valid (0x80) while stalled -> pc=0x80 with flush=1.
- Counter saturation and PC wrap: start from pc=0xFFFF_FFF8 -> pc=0xFFFF_FFFC, then 0x0000_0000. Force 65,536 redirects -> redirect_cnt=0xFFFF and holds.
- With PC_ALIGN_CHECK_EN: br_valid, br_target=0x1002 at pc=0x10 -> pc=0x14, no flush, misalign=1 and stays 1 until rst.

Source files
------------

// File: rtl/pc_redirect_unit.sv
// ============================================================================
// Module : pc_redirect_unit
// Brief  : IF-stage program-counter sequencer with branch/jump redirect
//          arbitration, stall handling and a one-cycle wrong-path flush.
//          Optional macro PC_ALIGN_CHECK_EN drops misaligned redirects and
//          raises a sticky misalign flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_INC   = 4,
    parameter int          CNT_W    = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             stall,
    input  wire logic             br_valid,
    input  wire logic [31:0]      br_target,
    input  wire logic             j_valid,
    input  wire logic [31:0]      j_target,
    input  wire logic             jr_valid,
    input  wire logic [31:0]      jr_target,
    output logic [31:0]           pc,
    output logic                  pc_valid,
    output logic                  flush,
`ifdef PC_ALIGN_CHECK_EN
    output logic                  misalign,
`endif
    output logic [CNT_W-1:0]      redirect_cnt
);

    localparam logic [1:0]  c_BOOT   = 2'd0;
    localparam logic [1:0]  c_RUN    = 2'd1;
    localparam logic [1:0]  c_SQUASH = 2'd2;
    localparam logic [31:0] c_PC_INC = 32'(PC_INC);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [31:0]      r_pc;
    logic             r_pc_valid;
    logic             r_flush;
    logic [CNT_W-1:0] r_cnt;

    logic             w_sel_valid;
    logic [31:0]      w_sel_target;
    logic             w_accept;
    logic [31:0]      w_pc_nxt;
    logic             w_pc_valid_nxt;
    logic             w_flush_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Priority pick; in SQUASH only the older EX branch is trusted, the ID
    // slot holds a wrong-path instruction.
    always_comb begin
        w_sel_valid  = 1'b0;
        w_sel_target = r_pc;
        if (r_state == c_RUN) begin
            if (br_valid) begin
                w_sel_valid  = 1'b1;
                w_sel_target = br_target;
            end else if (j_valid) begin
                w_sel_valid  = 1'b1;
                w_sel_target = j_target;
            end else if (jr_valid) begin
                w_sel_valid  = 1'b1;
                w_sel_target = jr_target;
            end
        end else if (r_state == c_SQUASH) begin
            if (br_valid) begin
                w_sel_valid  = 1'b1;
                w_sel_target = br_target;
            end
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic w_misaligned;
    logic r_misalign;

    // A dropped winner is not replaced by a lower-priority request.
    assign w_misaligned = w_sel_valid && (w_sel_target[1:0] != 2'b00);
    assign w_accept     = w_sel_valid && !w_misaligned;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else if (w_misaligned) begin
            r_misalign <= 1'b1;
        end
    end

    assign misalign = r_misalign;
`else
    assign w_accept = w_sel_valid;
`endif

    // State register plus the registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_BOOT;
            r_pc       <= RESET_PC;
            r_pc_valid <= 1'b0;
            r_flush    <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_pc_valid <= w_pc_valid_nxt;
            r_flush    <= w_flush_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = c_BOOT;
        case (r_state)
            c_BOOT:   w_state_nxt = c_RUN;
            c_RUN:    w_state_nxt = w_accept ? c_SQUASH : c_RUN;
            c_SQUASH: w_state_nxt = w_accept ? c_SQUASH : c_RUN;
            default:  w_state_nxt = c_BOOT;
        endcase
    end

    always_comb begin
        w_pc_nxt       = r_pc;
        w_pc_valid_nxt = r_pc_valid;
        w_flush_nxt    = 1'b0;
        w_cnt_nxt      = r_cnt;
        case (r_state)
            c_BOOT: begin
                w_pc_valid_nxt = 1'b1;
                w_pc_nxt       = RESET_PC;
            end
            c_RUN, c_SQUASH: begin
                w_pc_valid_nxt = 1'b1;
                if (w_accept) begin
                    w_pc_nxt    = w_sel_target;
                    w_flush_nxt = 1'b1;
                    w_cnt_nxt   = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
                end else if (!stall) begin
                    w_pc_nxt = r_pc + c_PC_INC;
                end
            end
            default: begin
                w_pc_valid_nxt = 1'b0;
                w_pc_nxt       = RESET_PC;
            end
        endcase
    end

    assign pc           = r_pc;
    assign pc_valid     = r_pc_valid;
    assign flush        = r_flush;
    assign redirect_cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pc_redirect_unit.sv
// ============================================================================
// Module : tb_pc_redirect_unit
// Brief  : Directed vector table plus hand sequences for pc_redirect_unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pc_redirect_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        br_valid;
    logic [31:0] br_target;
    logic        j_valid;
    logic [31:0] j_target;
    logic        jr_valid;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic        pc_valid;
    logic        flush;
    logic [15:0] redirect_cnt;
`ifdef PC_ALIGN_CHECK_EN
    logic        misalign;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pc_redirect_unit #(
        .RESET_PC(32'h0000_0000),
        .PC_INC  (4),
        .CNT_W   (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .br_valid    (br_valid),
        .br_target   (br_target),
        .j_valid     (j_valid),
        .j_target    (j_target),
        .jr_valid    (jr_valid),
        .jr_target   (jr_target),
        .pc          (pc),
        .pc_valid    (pc_valid),
        .flush       (flush),
`ifdef PC_ALIGN_CHECK_EN
        .misalign    (misalign),
`endif
        .redirect_cnt(redirect_cnt)
    );

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] brt;
        logic        j;
        logic [31:0] jt;
        logic        jr;
        logic [31:0] jrt;
        logic [31:0] pc;
        logic        fl;
        logic [15:0] cnt;
    } vec_t;

    localparam int NV = 23;
    vec_t tv[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic b, input logic [31:0] bt,
                         input logic j, input logic [31:0] jt,
                         input logic r, input logic [31:0] rt);
        stall     = s;
        br_valid  = b;
        br_target = bt;
        j_valid   = j;
        j_target  = jt;
        jr_valid  = r;
        jr_target = rt;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // Row: stall, br, brt, j, jt, jr, jrt -> pc, flush, cnt (pc_valid=1)
        tv[0]  = '{0, 1, 32'h0000_0999, 0, 0, 0, 0, 32'h0000_0000, 0, 16'd0}; // BOOT ignores br
        tv[1]  = '{0, 0, 0, 0, 0, 0, 0, 32'h0000_0004, 0, 16'd0};
        tv[2]  = '{0, 0, 0, 0, 0, 0, 0, 32'h0000_0008, 0, 16'd0};
        tv[3]  = '{0, 0, 0, 0, 0, 0, 0, 32'h0000_000C, 0, 16'd0};
        tv[4]  = '{1, 0, 0, 0, 0, 0, 0, 32'h0000_000C, 0, 16'd0};
        tv[5]  = '{1, 0, 0, 0, 0, 0, 0, 32'h0000_000C, 0, 16'd0};
        tv[6]  = '{1, 0, 0, 0, 0, 1, 32'h0000_0080, 32'h0000_0080, 1, 16'd1};
        tv[7]  = '{0, 0, 0, 0, 0, 0, 0, 32'h0000_0084, 0, 16'd1};
        tv[8]  = '{0, 0, 0, 1, 32'h0040_0020, 0, 0, 32'h0040_0020, 1, 16'd2};
        tv[9]  = '{0, 0, 0, 0, 0, 0, 0, 32'h0040_0024, 0, 16'd2};
        tv[10] = '{0, 1, 32'h0000_2000, 1, 32'h0000_3000, 0, 0, 32'h0000_2000, 1, 16'd3};
        tv[11] = '{0, 0, 0, 0, 0, 1, 32'h0000_4000, 32'h0000_2004, 0, 16'd3};
        tv[12] = '{0, 1, 32'h0000_2000, 1, 32'h0000_3000, 0, 0, 32'h0000_2000, 1, 16'd4};
        tv[13] = '{0, 1, 32'h0000_5000, 0, 0, 0, 0, 32'h0000_5000, 1, 16'd5};
        tv[14] = '{0, 0, 0, 1, 32'h0000_6000, 0, 0, 32'h0000_5004, 0, 16'd5};
        tv[15] = '{0, 0, 0, 1, 32'h0000_0100, 1, 32'h0000_0200, 32'h0000_0100, 1, 16'd6};
        tv[16] = '{1, 0, 0, 0, 0, 0, 0, 32'h0000_0100, 0, 16'd6};
        tv[17] = '{0, 0, 0, 0, 0, 1, 32'h0000_0300, 32'h0000_0300, 1, 16'd7};
        tv[18] = '{1, 0, 0, 1, 32'h0000_0700, 0, 0, 32'h0000_0300, 0, 16'd7};
        tv[19] = '{0, 1, 32'hFFFF_FFF8, 0, 0, 0, 0, 32'hFFFF_FFF8, 1, 16'd8};
        tv[20] = '{0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 16'd8};
        tv[21] = '{0, 0, 0, 0, 0, 0, 0, 32'h0000_0000, 0, 16'd8};
        tv[22] = '{0, 0, 0, 0, 0, 0, 0, 32'h0000_0004, 0, 16'd8};

        rst = 1'b1;
        idle();
        tick();
        tick();
        check("reset_pc",       pc, 32'h0);
        check("reset_pc_valid", {31'd0, pc_valid}, 32'd0);
        check("reset_flush",    {31'd0, flush}, 32'd0);
        check("reset_cnt",      {16'd0, redirect_cnt}, 32'd0);
`ifdef PC_ALIGN_CHECK_EN
        check("reset_misalign", {31'd0, misalign}, 32'd0);
`endif

        rst = 1'b0;
        for (int i = 0; i < NV; i++) begin
            drive(tv[i].stall, tv[i].br, tv[i].brt, tv[i].j, tv[i].jt, tv[i].jr, tv[i].jrt);
            tick();
            check($sformatf("vec%0d_pc", i),    pc, tv[i].pc);
            check($sformatf("vec%0d_valid", i), {31'd0, pc_valid}, 32'd1);
            check($sformatf("vec%0d_flush", i), {31'd0, flush}, {31'd0, tv[i].fl});
            check($sformatf("vec%0d_cnt", i),   {16'd0, redirect_cnt}, {16'd0, tv[i].cnt});
        end

        // Reset with a pending redirect; BOOT must also ignore the request.
        rst = 1'b1;
        drive(0, 1, 32'h0000_7000, 0, 0, 0, 0);
        tick();
        check("midrst_pc",    pc, 32'h0);
        check("midrst_valid", {31'd0, pc_valid}, 32'd0);
        check("midrst_flush", {31'd0, flush}, 32'd0);
        check("midrst_cnt",   {16'd0, redirect_cnt}, 32'd0);
        rst = 1'b0;
        tick();
        check("boot_pc",    pc, 32'h0);
        check("boot_valid", {31'd0, pc_valid}, 32'd1);
        check("boot_flush", {31'd0, flush}, 32'd0);
        idle();
        for (int i = 0; i < 4; i++) tick();
        check("pre_align_pc", pc, 32'h0000_0010);

        drive(0, 1, 32'h0000_1002, 1, 32'h0000_3000, 0, 0);
        tick();
`ifdef PC_ALIGN_CHECK_EN
        check("align_pc",       pc, 32'h0000_0014);
        check("align_flush",    {31'd0, flush}, 32'd0);
        check("align_cnt",      {16'd0, redirect_cnt}, 32'd0);
        check("align_misalign", {31'd0, misalign}, 32'd1);
        idle();
        tick();
        check("align_sticky_pc", pc, 32'h0000_0018);
        check("align_sticky",    {31'd0, misalign}, 32'd1);
`else
        check("unaligned_pc",    pc, 32'h0000_1002);
        check("unaligned_flush", {31'd0, flush}, 32'd1);
        check("unaligned_cnt",   {16'd0, redirect_cnt}, 32'd1);
        idle();
        tick();
        check("unaligned_next_pc", pc, 32'h0000_1006);
`endif

        rst = 1'b1;
        idle();
        tick();
`ifdef PC_ALIGN_CHECK_EN
        check("misalign_clear", {31'd0, misalign}, 32'd0);
`endif
        rst = 1'b0;
        tick();

        // Back-to-back branches keep the unit in SQUASH and drive the counter
        // into saturation.
        for (int i = 1; i <= 65537; i++) begin
            drive(0, 1, 32'(i) << 2, 0, 0, 0, 0);
            tick();
            if (i == 65534) check("sat_cnt_m1", {16'd0, redirect_cnt}, 32'h0000_FFFE);
            if (i == 65535) check("sat_cnt",    {16'd0, redirect_cnt}, 32'h0000_FFFF);
        end
        check("sat_cnt_hold", {16'd0, redirect_cnt}, 32'h0000_FFFF);
        check("sat_pc",       pc, 32'h0004_0004);
        check("sat_flush",    {31'd0, flush}, 32'd1);
        idle();
        tick();
        check("sat_after_pc",    pc, 32'h0004_0008);
        check("sat_after_flush", {31'd0, flush}, 32'd0);
        check("sat_after_cnt",   {16'd0, redirect_cnt}, 32'h0000_FFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
